neo_pbus_master: RTL and testbench



---
 rtl/neo_pbus_pkg.sv | 44 ++++
 rtl/neo_pbus_capture.sv | 44 ++++
 rtl/neo_pbus_master.sv | 146 ++++++++++++++
 tb/tb_neo_pbus_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/neo_pbus_pkg.sv
// neo_pbus_pkg
// Shared constants and types for the cartridge P bus initiator.
//   - Slot phase constants. A slot is 16 clocks and is indexed by a free-running 4-bit counter.
//   - Bus and data widths, which the protocol fixes.
//   - The capture-enable bundle that the top module passes to neo_pbus_capture.
//   - in_win(): the phase-window test that the strobe decode uses.
package neo_pbus_pkg;

  localparam int PBUS_W     = 24;
  localparam int CR_W       = 32;
  localparam int SPR_ADDR_W = 22;
  localparam int FIX_ADDR_W = 16;
  localparam int FIXD_W     = 8;

  typedef logic [3:0] phase_t;

  // First phase of each window within the 16-clock slot
  localparam phase_t PH_SPR_ADDR  = 4'd0;
  localparam phase_t PH_PCK1      = 4'd2;
  localparam phase_t PH_CA4_LO    = 4'd4;
  localparam phase_t PH_CA4_HI    = 4'd6;
  localparam phase_t PH_SPR_VALID = 4'd8;
  localparam phase_t PH_FIX_ADDR  = 4'd8;
  localparam phase_t PH_PCK2      = 4'd10;
  localparam phase_t PH_S2H1_LO   = 4'd10;
  localparam phase_t PH_S2H1_HI   = 4'd12;
  localparam phase_t PH_FIX_VALID = 4'd14;

  typedef struct packed {
    logic spr_hi;   // CR -> spr_data[63:32]
    logic spr_lo;   // CR -> spr_data[31:0]
    logic fix_hi;   // FIXD -> fix_data[15:8]
    logic fix_lo;   // FIXD -> fix_data[7:0]
  } cap_en_t;

  // True when ph lies in [lo, lo+len). The subtraction wraps modulo 16,
  // so a window may also straddle the slot boundary.
  function automatic logic in_win(input phase_t ph, input phase_t lo, input phase_t len);
    phase_t d;
    d = ph - lo;
    return d < len;
  endfunction

endpackage

// File: rtl/neo_pbus_capture.sv
// neo_pbus_capture
// Holds the returned C ROM and S ROM data for the video pipeline.
// A register changes only when its enable is set.
// Optional build macro: CR_BYTESWAP_EN. When it is defined, each 16-bit half of CR is
// byte-swapped before it is stored. This compensates for the byte order of the cartridge model.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   cap_en       per-half capture enables, decoded in the top module
//   cr, fixd     raw data from the cartridge
//   spr_data     {CR at CA4=0, CR at CA4=1}
//   fix_data     {FIXD at S2H1=0, FIXD at S2H1=1}
module neo_pbus_capture
  import neo_pbus_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  cap_en_t             cap_en,
  input  logic [CR_W-1:0]     cr,
  input  logic [FIXD_W-1:0]   fixd,
  output logic [2*CR_W-1:0]   spr_data,
  output logic [2*FIXD_W-1:0] fix_data
);

  logic [CR_W-1:0] cr_word;

`ifdef CR_BYTESWAP_EN
  assign cr_word = {cr[23:16], cr[31:24], cr[7:0], cr[15:8]};
`else
  assign cr_word = cr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_data <= '0;
      fix_data <= '0;
    end else begin
      if (cap_en.spr_hi) spr_data[2*CR_W-1:CR_W]     <= cr_word;
      if (cap_en.spr_lo) spr_data[CR_W-1:0]          <= cr_word;
      if (cap_en.fix_hi) fix_data[2*FIXD_W-1:FIXD_W] <= fixd;
      if (cap_en.fix_lo) fix_data[FIXD_W-1:0]        <= fixd;
    end
  end

endmodule

// File: rtl/neo_pbus_master.sv
// neo_pbus_master
// Motherboard-side P bus initiator. It time-multiplexes sprite (C ROM) and fix (S ROM)
// fetches into a 16-clock slot:
//   - phases 0-7:  sprite half
//   - phases 8-15: fix half
// All outputs are registered. Each output register is loaded from a decode of the *next*
// counter value, so the value shown during phase k is the one that phase k calls for.
// Requests are sampled on the edge that enters phase 0.
// Optional build macro: CR_BYTESWAP_EN (see neo_pbus_capture).
// Ports:
//   CLK_24M, nRESET      clock and asynchronous active-low reset
//   spr_req/addr/ack     sprite request handshake; ack pulses in phase 0
//   spr_valid/data       sprite data, valid in phase 8
//   fix_req/addr/ack     fix request handshake; ack pulses in phase 0
//   fix_valid/data       fix data, valid in phase 14
//   PBUS, PCK1B, PCK2B   address bus and latch strobes to the cartridge
//   CA4, S2H1            half selects
//   CR, FIXD             returned ROM data
module neo_pbus_master
  import neo_pbus_pkg::*;
(
  input  logic                  CLK_24M,
  input  logic                  nRESET,
  input  logic                  spr_req,
  input  logic [SPR_ADDR_W-1:0] spr_addr,
  output logic                  spr_ack,
  output logic                  spr_valid,
  output logic [2*CR_W-1:0]     spr_data,
  input  logic                  fix_req,
  input  logic [FIX_ADDR_W-1:0] fix_addr,
  output logic                  fix_ack,
  output logic                  fix_valid,
  output logic [2*FIXD_W-1:0]   fix_data,
  output logic [PBUS_W-1:0]     PBUS,
  output logic                  PCK1B,
  output logic                  PCK2B,
  output logic                  CA4,
  output logic                  S2H1,
  input  logic [CR_W-1:0]       CR,
  input  logic [FIXD_W-1:0]     FIXD
);

  phase_t cnt;
  phase_t cnt_nxt;
  logic   slot_start;

  logic                  spr_arm, spr_arm_nxt;
  logic                  fix_arm, fix_arm_nxt;
  logic [SPR_ADDR_W-1:0] spr_addr_q, spr_addr_nxt;
  logic [FIX_ADDR_W-1:0] fix_addr_q, fix_addr_nxt;

  logic [PBUS_W-1:0] pbus_nxt;
  logic              pck1_nxt, pck2_nxt, ca4_nxt, s2h1_nxt;
  logic              spr_ack_nxt, spr_valid_nxt, fix_ack_nxt, fix_valid_nxt;
  cap_en_t           cap_en;

  assign cnt_nxt    = cnt + 4'd1;
  assign slot_start = (cnt_nxt == PH_SPR_ADDR);

  // Request sampling and arming
  always_comb begin
    spr_arm_nxt  = spr_arm;
    fix_arm_nxt  = fix_arm;
    spr_addr_nxt = spr_addr_q;
    fix_addr_nxt = fix_addr_q;
    spr_ack_nxt  = 1'b0;
    fix_ack_nxt  = 1'b0;
    if (slot_start) begin
      spr_arm_nxt = spr_req;
      fix_arm_nxt = fix_req;
      spr_ack_nxt = spr_req;
      fix_ack_nxt = fix_req;
      if (spr_req) spr_addr_nxt = spr_addr;
      if (fix_req) fix_addr_nxt = fix_addr;
    end
  end

  // Output decode for the phase about to begin
  always_comb begin
    pbus_nxt = '0;
    if (spr_arm_nxt && in_win(cnt_nxt, PH_SPR_ADDR, 4'd4))
      pbus_nxt = {2'b00, spr_addr_nxt};
    else if (fix_arm_nxt && in_win(cnt_nxt, PH_FIX_ADDR, 4'd4))
      pbus_nxt = {8'h00, fix_addr_nxt};
    pck1_nxt      = spr_arm_nxt && in_win(cnt_nxt, PH_PCK1, 4'd2);
    pck2_nxt      = fix_arm_nxt && in_win(cnt_nxt, PH_PCK2, 4'd2);
    ca4_nxt       = in_win(cnt_nxt, PH_CA4_HI, 4'd2);
    s2h1_nxt      = in_win(cnt_nxt, PH_S2H1_HI, 4'd2);
    spr_valid_nxt = spr_arm_nxt && (cnt_nxt == PH_SPR_VALID);
    fix_valid_nxt = fix_arm_nxt && (cnt_nxt == PH_FIX_VALID);
  end

  // Capture on the last clock of each half-select window, while the cartridge data is settled
  always_comb begin
    cap_en        = '0;
    cap_en.spr_hi = spr_arm && (cnt == PH_CA4_LO + 4'd1);
    cap_en.spr_lo = spr_arm && (cnt == PH_CA4_HI + 4'd1);
    cap_en.fix_hi = fix_arm && (cnt == PH_S2H1_LO + 4'd1);
    cap_en.fix_lo = fix_arm && (cnt == PH_S2H1_HI + 4'd1);
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      cnt        <= '0;
      spr_arm    <= 1'b0;
      fix_arm    <= 1'b0;
      spr_addr_q <= '0;
      fix_addr_q <= '0;
      PBUS       <= '0;
      PCK1B      <= 1'b0;
      PCK2B      <= 1'b0;
      CA4        <= 1'b0;
      S2H1       <= 1'b0;
      spr_ack    <= 1'b0;
      fix_ack    <= 1'b0;
      spr_valid  <= 1'b0;
      fix_valid  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      spr_arm    <= spr_arm_nxt;
      fix_arm    <= fix_arm_nxt;
      spr_addr_q <= spr_addr_nxt;
      fix_addr_q <= fix_addr_nxt;
      PBUS       <= pbus_nxt;
      PCK1B      <= pck1_nxt;
      PCK2B      <= pck2_nxt;
      CA4        <= ca4_nxt;
      S2H1       <= s2h1_nxt;
      spr_ack    <= spr_ack_nxt;
      fix_ack    <= fix_ack_nxt;
      spr_valid  <= spr_valid_nxt;
      fix_valid  <= fix_valid_nxt;
    end
  end

  neo_pbus_capture u_capture (
    .clk      (CLK_24M),
    .rst_n    (nRESET),
    .cap_en   (cap_en),
    .cr       (CR),
    .fixd     (FIXD),
    .spr_data (spr_data),
    .fix_data (fix_data)
  );

endmodule

// File: tb/tb_neo_pbus_master.sv
module tb_neo_pbus_master;

  logic        CLK_24M = 1'b0;
  logic        nRESET;
  logic        spr_req;
  logic [21:0] spr_addr;
  logic        spr_ack, spr_valid;
  logic [63:0] spr_data;
  logic        fix_req;
  logic [15:0] fix_addr;
  logic        fix_ack, fix_valid;
  logic [15:0] fix_data;
  logic [23:0] PBUS;
  logic        PCK1B, PCK2B, CA4, S2H1;
  logic [31:0] CR;
  logic [7:0]  FIXD;

  // Data the cartridge model returns for the current slot
  logic [31:0] cr0, cr1;
  logic [7:0]  fd0, fd1;

  always #5 CLK_24M = ~CLK_24M;

  // Cartridge model: data follows the half selects
  assign CR   = CA4  ? cr1 : cr0;
  assign FIXD = S2H1 ? fd1 : fd0;

  neo_pbus_master dut (
    .CLK_24M   (CLK_24M),
    .nRESET    (nRESET),
    .spr_req   (spr_req),
    .spr_addr  (spr_addr),
    .spr_ack   (spr_ack),
    .spr_valid (spr_valid),
    .spr_data  (spr_data),
    .fix_req   (fix_req),
    .fix_addr  (fix_addr),
    .fix_ack   (fix_ack),
    .fix_valid (fix_valid),
    .fix_data  (fix_data),
    .PBUS      (PBUS),
    .PCK1B     (PCK1B),
    .PCK2B     (PCK2B),
    .CA4       (CA4),
    .S2H1      (S2H1),
    .CR        (CR),
    .FIXD      (FIXD)
  );

  typedef struct {
    logic        spr_en;
    logic [21:0] spr_addr;
    logic [31:0] cr0;
    logic [31:0] cr1;
    logic        fix_en;
    logic [15:0] fix_addr;
    logic [7:0]  fd0;
    logic [7:0]  fd1;
  } vec_t;

  vec_t vecs[8];
  vec_t idle_v;

  int checks = 0;
  int errors = 0;

  logic [63:0] spr_q[$];
  logic [15:0] fix_q[$];
  logic [63:0] last_spr;
  logic [15:0] last_fix;

  function automatic logic [31:0] swap_cr(input logic [31:0] w);
`ifdef CR_BYTESWAP_EN
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // {PBUS, PCK1B, PCK2B, CA4, S2H1, spr_ack, spr_valid, fix_ack, fix_valid}
  function automatic logic [31:0] exp_obs(input vec_t v, input int k);
    logic [23:0] pb;
    pb = '0;
    if (v.spr_en && k <= 3) pb = {2'b00, v.spr_addr};
    else if (v.fix_en && k >= 8 && k <= 11) pb = {8'h00, v.fix_addr};
    return {pb, v.spr_en && (k == 2 || k == 3), v.fix_en && (k == 10 || k == 11),
            (k == 6 || k == 7), (k == 12 || k == 13),
            v.spr_en && (k == 0), v.spr_en && (k == 8),
            v.fix_en && (k == 0), v.fix_en && (k == 14)};
  endfunction

  function automatic logic [31:0] got_obs();
    return {PBUS, PCK1B, PCK2B, CA4, S2H1, spr_ack, spr_valid, fix_ack, fix_valid};
  endfunction

  task automatic check_phase(input vec_t v, input int k);
    logic [31:0] g, e;
    logic [63:0] es;
    logic [15:0] ef;
    g = got_obs();
    e = exp_obs(v, k);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL phase_outputs k=%0d got=%h exp=%h", k, g, e);
    end
    if (spr_valid) begin
      checks++;
      if (spr_q.size() == 0) begin
        errors++;
        $display("FAIL spr_valid_unexpected k=%0d got=1 exp=0", k);
      end else begin
        es = spr_q.pop_front();
        last_spr = es;
        if (spr_data !== es) begin
          errors++;
          $display("FAIL spr_data got=%h exp=%h", spr_data, es);
        end
      end
    end
    if (fix_valid) begin
      checks++;
      if (fix_q.size() == 0) begin
        errors++;
        $display("FAIL fix_valid_unexpected k=%0d got=1 exp=0", k);
      end else begin
        ef = fix_q.pop_front();
        last_fix = ef;
        if (fix_data !== ef) begin
          errors++;
          $display("FAIL fix_data got=%h exp=%h", fix_data, ef);
        end
      end
    end
    if (k == 15) begin
      checks++;
      if (spr_data !== last_spr || fix_data !== last_fix) begin
        errors++;
        $display("FAIL data_hold got=%h/%h exp=%h/%h", spr_data, fix_data, last_spr, last_fix);
      end
    end
  endtask

  // Entered just after the negedge of phase 15 of the previous slot.
  // With abort_at < 16, the task asserts reset in that phase of the slot.
  task automatic do_slot(input vec_t v, input int abort_at);
    spr_req  = v.spr_en;
    fix_req  = v.fix_en;
    spr_addr = v.spr_en ? v.spr_addr : 22'($urandom);
    fix_addr = v.fix_en ? v.fix_addr : 16'($urandom);
    cr0 = v.cr0; cr1 = v.cr1; fd0 = v.fd0; fd1 = v.fd1;
    if (v.spr_en) spr_q.push_back({swap_cr(v.cr0), swap_cr(v.cr1)});
    if (v.fix_en) fix_q.push_back({v.fd0, v.fd1});
    for (int k = 0; k < 16; k++) begin
      @(posedge CLK_24M);
      @(negedge CLK_24M);
      check_phase(v, k);
      if (k == abort_at) begin
        nRESET = 1'b0;
        #1;
        checks++;
        if ({got_obs(), spr_data, fix_data} !== 112'd0) begin
          errors++;
          $display("FAIL async_reset got=%h/%h/%h exp=0", got_obs(), spr_data, fix_data);
        end
        spr_q.delete();
        fix_q.delete();
        last_spr = '0;
        last_fix = '0;
        return;
      end
    end
  endtask

  // Reset release at a negedge while the counter sits at 0. This runs the
  // unarmed remainder of that slot up to the negedge of phase 15.
  task automatic release_reset();
    spr_req = 1'b0;
    fix_req = 1'b0;
    repeat (2) @(negedge CLK_24M);
    nRESET = 1'b1;
    check_phase(idle_v, 0);
    for (int k = 1; k < 16; k++) begin
      @(posedge CLK_24M);
      @(negedge CLK_24M);
      check_phase(idle_v, k);
    end
  endtask

  initial begin
    idle_v = '{1'b0, 22'h0, 32'h0, 32'h0, 1'b0, 16'h0, 8'h0, 8'h0};
    vecs[0] = '{1'b1, 22'h2ABCDE, 32'h11223344, 32'h55667788, 1'b0, 16'h0,    8'h00, 8'h00};
    vecs[1] = '{1'b0, 22'h0,      32'hDEADDEAD, 32'hDEADDEAD, 1'b1, 16'hBEEF, 8'hA5, 8'h3C};
    vecs[2] = '{1'b1, 22'h012345, 32'hA0B1C2D3, 32'hE4F50617, 1'b1, 16'h1234, 8'h11, 8'h22};
    vecs[3] = '{1'b1, 22'h154321, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 16'h8001, 8'h5A, 8'hC3};
    vecs[4] = '{1'b1, 22'h3C0003, 32'h89ABCDEF, 32'h01234567, 1'b1, 16'h7FFE, 8'h99, 8'h66};
    vecs[5] = '{1'b0, 22'h0,      32'h12345678, 32'h9ABCDEF0, 1'b0, 16'h0,    8'h77, 8'h88};
    vecs[6] = idle_v;
    vecs[7] = '{1'b1, 22'h3FFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 16'h0000, 8'hFF, 8'h00};

    last_spr = '0;
    last_fix = '0;
    nRESET   = 1'b0;
    spr_req  = 1'b0;
    fix_req  = 1'b0;
    spr_addr = '0;
    fix_addr = '0;
    cr0 = '0; cr1 = '0; fd0 = '0; fd1 = '0;

    repeat (3) @(negedge CLK_24M);
    checks++;
    if ({got_obs(), spr_data, fix_data} !== 112'd0) begin
      errors++;
      $display("FAIL reset_state got=%h/%h/%h exp=0", got_obs(), spr_data, fix_data);
    end
    release_reset();

    for (int i = 0; i < 8; i++) do_slot(vecs[i], 16);

    // Reset in phase 5 of an armed slot: the fetch is abandoned and no valid pulse follows
    do_slot(vecs[2], 5);
    release_reset();
    do_slot(vecs[0], 16);
    do_slot(vecs[1], 16);

    checks++;
    if (spr_q.size() != 0 || fix_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", spr_q.size(), fix_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
